// File: rtl/mul_25519.sv
// Iterative GF(2^255-19) modular multiplier: MSB-first interleaved double-and-add,
// one bit of b per cycle, with valid/ready handshakes on both sides.
module mul_25519 #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  localparam int CntW = $clog2(N);
  localparam logic [N:0] P  = (257'd1 << 255) - 257'd19;
  localparam logic [N:0] P2 = P << 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    aReg_q, aReg_d;
  logic [N-1:0]    bReg_q, bReg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    aRed;
  logic [N:0]      dbl;
  logic [N-1:0]    dblRed;
  logic [N:0]      sum;
  logic [N-1:0]    sumRed;
  logic [N-1:0]    stepVal;

  // Reduced results are always < P, so truncating to N bits after subtracting is exact.
  always_comb begin
    if ({1'b0, a} >= P2) begin
      aRed = a - P2[N-1:0];
    end else if ({1'b0, a} >= P) begin
      aRed = a - P[N-1:0];
    end else begin
      aRed = a;
    end

    dbl = {acc_q, 1'b0};
    if (dbl >= P) begin
      dblRed = dbl[N-1:0] - P[N-1:0];
    end else begin
      dblRed = dbl[N-1:0];
    end

    sum = {1'b0, dblRed} + {1'b0, aReg_q};
    if (sum >= P) begin
      sumRed = sum[N-1:0] - P[N-1:0];
    end else begin
      sumRed = sum[N-1:0];
    end

    stepVal = bReg_q[cnt_q] ? sumRed : dblRed;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          aReg_d  = aRed;
          bReg_d  = b;
          acc_d   = '0;
          cnt_d   = CntW'(N - 1);
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = stepVal;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      aReg_q  <= '0;
      bReg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL);
  assign out_valid = (state_q == DONE);
  assign res       = acc_q;

endmodule

// File: doc/mul_25519.md
Name: mul_25519

Overview:
- Iterative modular multiplier over GF(2^255-19): computes res = a*b mod P with radix-2, MSB-first, interleaved double-and-add, one bit of b per cycle.
- Sits beside the field add/sub unit in the Ed25519 point-arithmetic datapath; its output feeds the add/sub stage directly.
- Output is always fully reduced (< P), so it meets the add/sub stage's reduced-operand requirement.
- Valid/ready handshake on input and output.

Parameters:
- N, 256, operand/result width in bits (fixed; the iteration count equals N).
- P, 256'h7FFF...FFED (2^255-19), field modulus.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands.
- a  input  256  multiplicand; any 256-bit value, reduced internally.
- b  input  256  multiplier; any 256-bit value, scanned bit by bit.
- out_valid  output  1  res holds a completed product.
- out_ready  input  1  consumer takes res.
- res  output  256  product a*b mod P, always < P.
- busy  output  1  high while iterating (state MUL).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, acc=0, cnt=0, a_reg=0, b_reg=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, res=0.
  - Reset applied mid-operation discards all work; the next cycle behaves as IDLE.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - a_reg <= a mod P, reduced in one cycle by comparing a against P and 2P. 2^256-1 = 2P+37, so at most two subtractions of P are needed.
    - b_reg <= b, acc <= 0, cnt <= N-1, go to MUL.
- MUL (in_ready=0, busy=1). Each edge performs:
  - d = 2*acc (257-bit); if d >= P then d = d-P.
  - If b_reg[cnt]=1: s = d + a_reg (257-bit); if s >= P then s = s-P; else s = d.
  - acc <= s.
  - If cnt==0, go to DONE; else cnt <= cnt-1.
- Invariant: acc < P after every step. Intermediate sums never exceed 2P-2, so the 257-bit internal width suffices.
- Latency: accept edge T, MUL edges T+1..T+256, out_valid=1 after edge T+256. Throughput is one product per 258 cycles minimum.
- DONE:
  - out_valid=1, res=acc, in_ready=0, busy=0.
  - On an edge with out_ready=1: go to IDLE; acc is left intact.
- res is driven from acc and is meaningful only while out_valid=1.
- Backpressure: DONE holds res and out_valid stable indefinitely while out_ready=0.
- in_valid asserted outside IDLE is ignored; no operands are latched.
- Input and output handshakes never complete in the same cycle, because in_ready=0 in DONE.
- out_ready outside DONE has no effect.

Test Plan:
- a=3, b=5, in_valid for one cycle, out_ready=1 → out_valid rises exactly 256 cycles after the accept edge, res=15, then in_ready returns to 1.
- a=P-1, b=P-1 → res=1. Also a=P-1, b=2 → res=P-2.
- Unreduced inputs: a=P+5, b=2 → res=10. a=2^256-1, b=1 → res=37. a=7, b=2^256-1 → res=7*37 mod P=259.
- a=0xFFFF, b=0 → res=0; a=0, b=P-1 → res=0. Also random a/b (≥200 pairs) checked against a reference model, including b with bit 255 set.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → res/out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle; a new op then returns the correct product.
- Reset mid-op: drop rst_n for one edge at iteration 100 → next cycle in_ready=1, out_valid=0, busy=0, res=0. A subsequent a=3, b=5 returns 15 with full 256-cycle latency.
